// File: rtl/pmem_arbiter_pkg.sv
// Shared RV32I memory-side types: word/line typedefs, burst geometry and
// the state/grant encodings used by the physical-memory arbiter.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] rv32i_line;

    // 64-bit beats per 256-bit cache line
    localparam int PMEM_BEATS  = 4;
    localparam int PMEM_BEAT_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INST_RD = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4
    } pmem_arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } pmem_grant_t;

    // Clear the byte-in-line offset so bursts always start on a line boundary.
    function automatic rv32i_word line_align(input rv32i_word addr);
        return addr & ~rv32i_word'(31);
    endfunction

endpackage

// File: rtl/pmem_arbiter_line_beat_buffer.sv
// Shared line buffer for the arbiter: holds one cache line, tracks which
// 64-bit beat of the burst is current, inserts read beats and selects the
// outgoing write beat.
module line_beat_buffer
    import rv32i_types::*;
#(
    parameter int BEATS = PMEM_BEATS
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  load_i,
    input  logic [64*BEATS-1:0]   line_i,
    input  logic                  ack_i,
    input  logic                  store_i,
    input  logic [63:0]           beat_i,
    output logic [64*BEATS-1:0]   line_o,
    output logic [63:0]           beat_o,
    output logic                  last_o
);

    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = 64 * BEATS;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [LINE_W-1:0] line_q, line_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Next line contents and beat index: a new burst rewinds the counter
    // (and takes the writeback line), each acknowledged beat advances it.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            cnt_d = '0;
            if (load_i) begin
                line_d = line_i;
            end
        end else if (ack_i) begin
            if (store_i) begin
                line_d[cnt_q*64 +: 64] = beat_i;
            end
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Line and counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[cnt_q*64 +: 64];
    assign last_o = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto a single burst
// memory port. One line transfer at a time; ties alternate between the two
// caches, and the winner gets a single-cycle completion pulse.
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int BEATS = PMEM_BEATS
)
(
    input  logic        clk,
    input  logic        rst,

    input  rv32i_word   inst_pmem_address,
    input  logic        inst_pmem_read,
    output rv32i_line   inst_pmem_rdata,
    output logic        inst_pmem_resp,

    input  rv32i_word   data_pmem_address,
    input  logic        data_pmem_read,
    input  logic        data_pmem_write,
    input  rv32i_line   data_pmem_wdata,
    output rv32i_line   data_pmem_rdata,
    output logic        data_pmem_resp,

    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [63:0] pmem_wdata,
    output rv32i_word   pmem_addr
);

    pmem_arb_state_t state_q, state_d;
    pmem_grant_t     last_grant_q, last_grant_d;
    rv32i_word       addr_q, addr_d;

    logic      inst_req;
    logic      data_req;
    logic      grant;
    logic      grant_inst;
    logic      in_burst;
    logic      beat_ack;
    logic      last_beat;
    logic      load_line;
    logic      store_beat;
    rv32i_line line;

    // Request decode and round-robin pick; a grant only happens from IDLE.
    always_comb begin
        inst_req   = inst_pmem_read;
        data_req   = data_pmem_read | data_pmem_write;
        grant_inst = inst_req && (!data_req || (last_grant_q == GNT_DATA));
        grant      = (state_q == IDLE) && (inst_req || data_req);
    end

    // Next state, last-grant and latched burst address.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    if (grant_inst) begin
                        state_d      = INST_RD;
                        last_grant_d = GNT_INST;
                        addr_d       = line_align(inst_pmem_address);
                    end else begin
                        // read+write together is a writeback
                        state_d      = data_pmem_write ? DATA_WR : DATA_RD;
                        last_grant_d = GNT_DATA;
                        addr_d       = line_align(data_pmem_address);
                    end
                end
            end
            INST_RD, DATA_RD, DATA_WR: begin
                if (pmem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // no re-grant here: requesters get this cycle to drop
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; a reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DATA;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
        end
    end

    assign in_burst   = (state_q == INST_RD) || (state_q == DATA_RD) || (state_q == DATA_WR);
    assign beat_ack   = in_burst && pmem_resp;
    assign load_line  = grant && !grant_inst && data_pmem_write;
    assign store_beat = (state_q != DATA_WR);

    line_beat_buffer #(
        .BEATS   (BEATS)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .start_i (grant),
        .load_i  (load_line),
        .line_i  (data_pmem_wdata),
        .ack_i   (beat_ack),
        .store_i (store_beat),
        .beat_i  (pmem_rdata),
        .line_o  (line),
        .beat_o  (pmem_wdata),
        .last_o  (last_beat)
    );

    assign pmem_read       = (state_q == INST_RD) || (state_q == DATA_RD);
    assign pmem_write      = (state_q == DATA_WR);
    assign pmem_addr       = addr_q;
    assign inst_pmem_resp  = (state_q == DONE) && (last_grant_q == GNT_INST);
    assign data_pmem_resp  = (state_q == DONE) && (last_grant_q == GNT_DATA);
    assign inst_pmem_rdata = line;
    assign data_pmem_rdata = line;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed table of single transactions, hand
// sequences for ties and mid-burst reset, then random traffic against a
// transaction-level model of the arbiter.
module tb_pmem_arbiter;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_pmem_address;
    logic        inst_pmem_read;
    logic [255:0] inst_pmem_rdata;
    logic        inst_pmem_resp;
    logic [31:0] data_pmem_address;
    logic        data_pmem_read;
    logic        data_pmem_write;
    logic [255:0] data_pmem_wdata;
    logic [255:0] data_pmem_rdata;
    logic        data_pmem_resp;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [63:0] pmem_wdata;
    logic [31:0] pmem_addr;

    pmem_arbiter #(.BEATS(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_pmem_address (inst_pmem_address),
        .inst_pmem_read    (inst_pmem_read),
        .inst_pmem_rdata   (inst_pmem_rdata),
        .inst_pmem_resp    (inst_pmem_resp),
        .data_pmem_address (data_pmem_address),
        .data_pmem_read    (data_pmem_read),
        .data_pmem_write   (data_pmem_write),
        .data_pmem_wdata   (data_pmem_wdata),
        .data_pmem_rdata   (data_pmem_rdata),
        .data_pmem_resp    (data_pmem_resp),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_wdata        (pmem_wdata),
        .pmem_addr         (pmem_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] addr;
        int          gap;
        logic [255:0] wline;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic        exp_inst;
        int          exp_cycles;
    } row_t;

    row_t rows[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read beat k of the directed memory: 0x1111.., 0x2222.., 0x3333.., 0x4444..
    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'((k + 1) * 17);
        return {8{b}};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in the first cycle after the grant edge. Acks beats with 'gap'
    // idle cycles before each one and returns in the cycle resp is seen.
    task automatic serve(input string nm, input logic [31:0] exp_addr, input logic exp_wr,
                         input logic exp_inst, input logic [255:0] wline, input int gap,
                         output int cyc);
        int  sent;
        int  g;
        int  cmd_cyc;
        bit  seen;
        sent = 0; g = 0; cmd_cyc = 0; seen = 0; cyc = 1;
        for (int n = 0; n < 64; n++) begin
            cyc++;
            if (inst_pmem_resp || data_pmem_resp) begin
                seen = 1;
                chk({nm, " resp_inst"}, 256'(inst_pmem_resp), 256'(exp_inst));
                chk({nm, " resp_data"}, 256'(data_pmem_resp), 256'(!exp_inst));
                chk({nm, " cmd_done"}, 256'({pmem_read, pmem_write}), 256'(0));
                if (!exp_wr)
                    chk({nm, " rdata"}, exp_inst ? inst_pmem_rdata : data_pmem_rdata,
                        {pat(3), pat(2), pat(1), pat(0)});
                break;
            end
            if (pmem_read || pmem_write) cmd_cyc++;
            if (sent < 4) begin
                chk({nm, " cmd"}, 256'({pmem_read, pmem_write}), 256'({!exp_wr, exp_wr}));
                chk({nm, " addr"}, 256'(pmem_addr), 256'(exp_addr));
                if (exp_wr) chk({nm, " wdata"}, 256'(pmem_wdata), 256'(wline[64*sent +: 64]));
                if (g < gap) begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = {$urandom, $urandom};
                    g++;
                end else begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = pat(sent);
                    sent++;
                    g = 0;
                end
            end else begin
                pmem_resp = 1'b1;
            end
            tick();
        end
        if (!seen) chk({nm, " resp_timeout"}, 256'(0), 256'(1));
        chk({nm, " cmd_cycles"}, 256'(cmd_cyc), 256'(4 * (gap + 1)));
    endtask

    task automatic run_row(input row_t r, input string nm);
        int cyc;
        inst_pmem_read    = r.ir;
        data_pmem_read    = r.dr;
        data_pmem_write   = r.dw;
        inst_pmem_address = r.addr;
        data_pmem_address = r.addr;
        data_pmem_wdata   = r.wline;
        pmem_resp         = 1'($urandom_range(0, 1));
        pmem_rdata        = {$urandom, $urandom};
        chk({nm, " idle_cmd"}, 256'({pmem_read, pmem_write}), 256'(0));
        tick();
        inst_pmem_read    = 1'b0;
        data_pmem_read    = 1'b0;
        data_pmem_write   = 1'b0;
        inst_pmem_address = $urandom;
        data_pmem_address = $urandom;
        data_pmem_wdata   = {8{$urandom}};
        serve(nm, r.exp_addr, r.exp_wr, r.exp_inst, r.wline, r.gap, cyc);
        chk({nm, " cycles"}, 256'(cyc), 256'(r.exp_cycles));
        pmem_resp = 1'b0;
        tick();
        chk({nm, " resp_pulse"}, 256'({inst_pmem_resp, data_pmem_resp}), 256'(0));
    endtask

    task automatic tie_round(input string nm);
        int cyc;
        inst_pmem_read    = 1'b1;
        data_pmem_read    = 1'b1;
        data_pmem_write   = 1'b0;
        inst_pmem_address = 32'h0000_0100;
        data_pmem_address = 32'h0000_0200;
        pmem_resp         = 1'b0;
        tick();
        inst_pmem_read = 1'b0;
        serve({nm, " first"}, 32'h0000_0100, 1'b0, 1'b1, '0, 0, cyc);
        pmem_resp = 1'b0;
        tick();
        chk({nm, " no_regrant_in_done"}, 256'({pmem_read, pmem_write}), 256'(0));
        tick();
        data_pmem_read = 1'b0;
        serve({nm, " second"}, 32'h0000_0200, 1'b0, 1'b0, '0, 0, cyc);
        pmem_resp = 1'b0;
        tick();
    endtask

    // Random traffic against a transaction-level model of the arbiter.
    task automatic random_phase(input int ncyc);
        bit          m_busy, m_done, m_inst, m_wr, m_last_inst;
        logic [31:0] m_addr;
        logic [255:0] m_line;
        int          m_k;
        bit          ireq, dreq;
        m_busy = 0; m_done = 0; m_inst = 0; m_wr = 0; m_last_inst = 0;
        m_addr = '0; m_line = '0; m_k = 0;
        for (int n = 0; n < ncyc; n++) begin
            chk("rnd pmem_read", 256'(pmem_read), 256'(m_busy && !m_wr));
            chk("rnd pmem_write", 256'(pmem_write), 256'(m_busy && m_wr));
            chk("rnd inst_resp", 256'(inst_pmem_resp), 256'(m_done && m_inst));
            chk("rnd data_resp", 256'(data_pmem_resp), 256'(m_done && !m_inst));
            if (m_done && !m_wr)
                chk("rnd rdata", m_inst ? inst_pmem_rdata : data_pmem_rdata, m_line);
            if (m_busy) begin
                chk("rnd addr", 256'(pmem_addr), 256'(m_addr));
                if (m_wr) chk("rnd wdata", 256'(pmem_wdata), 256'(m_line[64*m_k +: 64]));
            end

            inst_pmem_read    = ($urandom_range(0, 3) == 0);
            data_pmem_read    = ($urandom_range(0, 3) == 0);
            data_pmem_write   = ($urandom_range(0, 4) == 0);
            inst_pmem_address = $urandom;
            data_pmem_address = $urandom;
            data_pmem_wdata   = {8{$urandom}};
            pmem_resp         = 1'($urandom_range(0, 1));
            pmem_rdata        = {$urandom, $urandom};

            ireq = inst_pmem_read;
            dreq = data_pmem_read || data_pmem_write;
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (pmem_resp) begin
                    if (!m_wr) m_line[64*m_k +: 64] = pmem_rdata;
                    m_k++;
                    if (m_k == 4) begin
                        m_busy = 0;
                        m_done = 1;
                        m_k    = 0;
                    end
                end
            end else if (ireq || dreq) begin
                m_inst      = ireq && (!dreq || !m_last_inst);
                m_last_inst = m_inst;
                m_wr        = !m_inst && data_pmem_write;
                m_addr      = (m_inst ? inst_pmem_address : data_pmem_address) & ~32'd31;
                if (m_wr) m_line = data_pmem_wdata;
                m_k    = 0;
                m_busy = 1;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        inst_pmem_address = '0;
        inst_pmem_read    = 1'b0;
        data_pmem_address = '0;
        data_pmem_read    = 1'b0;
        data_pmem_write   = 1'b0;
        data_pmem_wdata   = '0;
        pmem_rdata        = '0;
        pmem_resp         = 1'b0;

        rows[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, 0, {4{64'h5A5A_5A5A_5A5A_5A5A}},
                    32'h0000_0060, 1'b0, 1'b1, 6};
        rows[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_1000, 0,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    32'h0000_1000, 1'b1, 1'b0, 6};
        rows[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_2013, 1,
                    {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003,
                     64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001},
                    32'h0000_2000, 1'b1, 1'b0, 10};
        rows[3] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 2, {4{64'h0123_4567_89AB_CDEF}},
                    32'hFFFF_FFE0, 1'b0, 1'b0, 14};
        rows[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_001F, 1, '0,
                    32'h0000_0000, 1'b0, 1'b1, 10};

        #1;
        chk("reset cmd", 256'({pmem_read, pmem_write}), 256'(0));
        chk("reset resp", 256'({inst_pmem_resp, data_pmem_resp}), 256'(0));
        chk("reset addr", 256'(pmem_addr), 256'(0));
        chk("reset line", inst_pmem_rdata, 256'(0));
        tick();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_row(rows[i], $sformatf("row%0d", i));
        end

        do_reset();
        tie_round("tie1");
        tie_round("tie2");

        // reset after two beats of an inst read
        inst_pmem_read    = 1'b1;
        inst_pmem_address = 32'h0000_0300;
        pmem_resp         = 1'b0;
        tick();
        inst_pmem_read = 1'b0;
        pmem_resp      = 1'b1;
        pmem_rdata     = pat(0);
        tick();
        pmem_rdata = pat(1);
        tick();
        pmem_resp = 1'b0;
        chk("rst_mid busy", 256'(pmem_read), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid cmd", 256'({pmem_read, pmem_write}), 256'(0));
        chk("rst_mid addr", 256'(pmem_addr), 256'(0));
        chk("rst_mid line", inst_pmem_rdata, 256'(0));
        chk("rst_mid resp", 256'({inst_pmem_resp, data_pmem_resp}), 256'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid no_resp", 256'({inst_pmem_resp, data_pmem_resp, pmem_read, pmem_write}),
                256'(0));
            tick();
        end
        run_row(rows[0], "after_rst");

        do_reset();
        random_phase(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter BEATS, default 4, giving the number of 64-bit beats per 256-bit cache line.
REQ-002 SHALL have port clk  in  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port inst_pmem_address  in  32  I-cache line address.
REQ-005 SHALL have port inst_pmem_read  in  1  I-cache line read request.
REQ-006 SHALL have port inst_pmem_rdata  out  256  line returned to the I-cache.
REQ-007 SHALL have port inst_pmem_resp  out  1  I-cache completion pulse.
REQ-008 SHALL have port data_pmem_address  in  32  D-cache line address.
REQ-009 SHALL have port data_pmem_read  in  1  D-cache line read request.
REQ-010 SHALL have port data_pmem_write  in  1  D-cache writeback request.
REQ-011 SHALL have port data_pmem_wdata  in  256  D-cache writeback line.
REQ-012 SHALL have port data_pmem_rdata  out  256  line returned to the D-cache.
REQ-013 SHALL have port data_pmem_resp  out  1  D-cache completion pulse.
REQ-014 SHALL have port pmem_rdata  in  64  memory read beat.
REQ-015 SHALL have port pmem_resp  in  1  memory beat acknowledge.
REQ-016 SHALL have ports pmem_read, pmem_write  out  1  memory burst read and burst write commands.
REQ-017 SHALL have ports pmem_wdata  out  64, and pmem_addr  out  32  write beat and burst address.

Function
REQ-018 SHALL implement states IDLE, INST_RD, DATA_RD, DATA_WR and DONE.
REQ-019 SHALL arbitrate in IDLE only:
- single pending requester: grant it.
- inst and data both pending: grant the requester not served last (round-robin).
- last_grant resets to DATA, so the first tie goes to inst.
REQ-020 SHALL treat a data request with both read and write high as a write.
REQ-021 SHALL latch the granted address with bits [4:0] forced to 0, and for writes the 256-bit wdata, on the grant edge; requester input changes mid-burst SHALL be ignored.
REQ-022 SHALL hold pmem_read or pmem_write high, and pmem_addr constant, from the cycle after grant until the cycle the final beat is acknowledged.
REQ-023 SHALL advance a beat counter (0..BEATS-1) on each cycle pmem_resp is high; beats MAY be non-consecutive.
REQ-024 SHALL on read store pmem_rdata into line bits [64k+63:64k] when beat k is acknowledged.
REQ-025 SHALL on write drive pmem_wdata = latched line bits [64k+63:64k] while the counter equals k.
REQ-026 SHALL enter DONE on the final-beat acknowledge, and deassert both pmem commands in DONE.
REQ-027 SHALL in DONE assert exactly one cycle of inst_pmem_resp or data_pmem_resp for the granted requester, then return to IDLE.
REQ-028 SHALL drive inst_pmem_rdata and data_pmem_rdata from the shared line buffer; contents are valid only while the corresponding resp is high.
REQ-029 SHALL ignore pmem_resp in IDLE and DONE.
REQ-030 SHALL not re-grant in the DONE cycle, giving requesters one cycle to drop their request.
REQ-031 SHALL complete a burst in BEATS+2 cycles minimum (grant, BEATS beats, DONE).

Reset
REQ-032 SHALL, on rst high, asynchronously force:
- state = IDLE, beat counter = 0, last_grant = DATA;
- line buffer, latched address and pmem_addr = 0;
- all resp and pmem command outputs = 0.
REQ-033 SHALL on a reset mid-burst abandon the burst with no resp pulse, and restart arbitration on the first edge after release.

Structure
REQ-034 SHALL take rv32i_word, rv32i_line and a new constant PMEM_BEATS (4) from package rv32i_types; the state enum pmem_arb_state_t SHALL also be added to rv32i_types.
REQ-035 SHALL instantiate one sub-module, line_beat_buffer, holding the 256-bit line, beat counter, beat insert and beat select logic.

Verification
REQ-036 SHALL verify: inst read 0x0000_0064, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> pmem_addr = 0x0000_0060, inst_pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, inst_pmem_resp high for 1 cycle, 6 cycles total.
REQ-037 SHALL verify: data write 0x0000_1000 with wdata beats A,B,C,D -> pmem_wdata = A,B,C,D in order, pmem_write held 4 beats, one data_pmem_resp pulse.
REQ-038 SHALL verify: inst and data reads raised in the same cycle after reset -> inst served first, then data; repeat the tie -> inst first again, since last_grant returns to DATA after the data grant.
REQ-039 SHALL verify: pmem_resp with 2 idle cycles between beats and the address changed mid-burst -> pmem_addr stays stable and the assembled line is correct.
REQ-040 SHALL verify: rst asserted after beat 2 of a read -> outputs zero immediately, no resp pulse; the next request completes normally.
